// File: rtl/pipe_issue_if.sv
// pipe_issue_if: instruction input handshake plus the registered issue bus
interface pipe_issue_if;
  logic in_valid, in_ready;
  logic [3:0] in_rs1, in_rs2, in_rd, in_func;
  logic [7:0] in_addr;
  logic iss_valid;
  logic [3:0] iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0] iss_addr;
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
    input in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
  );
  modport slave (
    input in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
    output in_ready, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: FIFO-buffered in-order issue with a shift-register RAW scoreboard
module pipe_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int LAT = 3,
  parameter int CW = 16
) (
  input logic clk,
  input logic rst,
  pipe_issue_if.slave bus,
  input logic flush,
  output logic busy,
  output logic [CW-1:0] issue_cnt,
  output logic [CW-1:0] stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [23:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [LAT-1:0] sb_v;
  logic [3:0] sb_rd [LAT];
  logic [23:0] head;
  logic empty, hazard, push, issue, stall;
  assign head = mem[rp];
  assign empty = cnt == '0;
  assign bus.in_ready = !rst && cnt != (AW+1)'(DEPTH);
  assign push = bus.in_valid && bus.in_ready && !flush;
  assign issue = !empty && !hazard && !flush && !rst;
  assign stall = !empty && hazard && !flush;
  assign busy = !empty || |sb_v;
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LAT; i++)
      hazard = hazard | (sb_v[i] && (sb_rd[i] == head[23:20] || sb_rd[i] == head[19:16]));
  end
  // storage and scoreboard rd tags carry no reset; their valid bits gate them
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_func, bus.in_addr};
    sb_rd[0] <= head[15:12];
    for (int i = 1; i < LAT; i++) sb_rd[i] <= sb_rd[i-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      sb_v <= '0;
      bus.iss_valid <= 1'b0;
      {bus.iss_rs1, bus.iss_rs2, bus.iss_rd, bus.iss_func, bus.iss_addr} <= '0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (issue) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(issue);
      end
      sb_v <= (sb_v << 1) | LAT'(issue);
      bus.iss_valid <= issue;
      if (issue) {bus.iss_rs1, bus.iss_rs2, bus.iss_rd, bus.iss_func, bus.iss_addr} <= head;
      if (issue && !(&issue_cnt)) issue_cnt <= issue_cnt + 1'b1;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl: directed scenario tasks with hand-computed expectations
module tb_pipe_issue_ctrl;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, busy;
  logic [3:0] issue_cnt, stall_cnt;
  logic [23:0] iss_w;
  int tests = 0, fails = 0;
  pipe_issue_if bus();
  pipe_issue_ctrl #(.DEPTH(4), .LAT(3), .CW(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  assign iss_w = {bus.iss_rs1, bus.iss_rs2, bus.iss_rd, bus.iss_func, bus.iss_addr};

  function automatic logic [23:0] ins(input int rs1, rs2, rd, func, addr);
    return {4'(rs1), 4'(rs2), 4'(rd), 4'(func), 8'(addr)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] f);
    bus.in_valid = v;
    {bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_func, bus.in_addr} = f;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b1, ins(1, 2, 3, 4, 5));
    step();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", bus.in_ready); end
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL rst_iss_valid got %b exp 0", bus.iss_valid); end
    tests++; if (issue_cnt !== 4'd0) begin fails++; $display("FAIL rst_issue_cnt got %0d exp 0", issue_cnt); end
    tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b exp 0", busy); end
    step();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready2 got %b exp 0", bus.in_ready); end
    rst = 1'b0;
    drive(1'b0, '0);
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", bus.in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_release_busy got %b exp 0", busy); end
    step();
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL rst_nothing_queued got %b exp 0", bus.iss_valid); end
  endtask

  task automatic test_independent();
    logic [23:0] a [3];
    a[0] = ins(3, 5, 10, 0, 125);
    a[1] = ins(3, 8, 12, 2, 126);
    a[2] = ins(1, 2, 13, 1, 127);
    do_reset();
    drive(1'b1, a[0]);
    step();
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL ind_latency got %b exp 0", bus.iss_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, i < 2 ? a[i+1] : 24'd0);
      step();
      tests++; if (bus.iss_valid !== 1'b1) begin fails++; $display("FAIL ind_valid%0d got %b exp 1", i, bus.iss_valid); end
      tests++; if (iss_w !== a[i]) begin fails++; $display("FAIL ind_fields%0d got %h exp %h", i, iss_w, a[i]); end
    end
    step();
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL ind_tail got %b exp 0", bus.iss_valid); end
    tests++; if (issue_cnt !== 4'd3) begin fails++; $display("FAIL ind_issue_cnt got %0d exp 3", issue_cnt); end
    tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL ind_stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_raw(input bit on_rs2);
    logic [23:0] a, b;
    a = ins(3, 5, 10, 0, 125);
    b = on_rs2 ? ins(4, 10, 11, 1, 126) : ins(10, 4, 11, 1, 126);
    do_reset();
    drive(1'b1, a);
    step();
    drive(1'b1, b);
    step();
    tests++; if (iss_w !== a || bus.iss_valid !== 1'b1) begin fails++; $display("FAIL raw%0d_producer got %b/%h exp 1/%h", on_rs2, bus.iss_valid, iss_w, a); end
    drive(1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL raw%0d_bubble%0d got %b exp 0", on_rs2, k, bus.iss_valid); end
    end
    step();
    tests++; if (bus.iss_valid !== 1'b1 || iss_w !== b) begin fails++; $display("FAIL raw%0d_consumer got %b/%h exp 1/%h", on_rs2, bus.iss_valid, iss_w, b); end
    tests++; if (stall_cnt !== 4'd3) begin fails++; $display("FAIL raw%0d_stall_cnt got %0d exp 3", on_rs2, stall_cnt); end
    tests++; if (issue_cnt !== 4'd2) begin fails++; $display("FAIL raw%0d_issue_cnt got %0d exp 2", on_rs2, issue_cnt); end
  endtask

  task automatic test_full();
    logic [23:0] e [6];
    e[0] = ins(0, 0, 5, 0, 1);
    e[1] = ins(5, 0, 6, 0, 2);
    e[2] = ins(1, 1, 7, 1, 3);
    e[3] = ins(2, 2, 8, 2, 4);
    e[4] = ins(3, 3, 9, 3, 5);
    e[5] = ins(4, 4, 10, 4, 6);
    do_reset();
    drive(1'b1, e[0]);
    step();
    drive(1'b1, e[1]);
    step();
    tests++; if (iss_w !== e[0] || bus.iss_valid !== 1'b1) begin fails++; $display("FAIL full_writer got %b/%h exp 1/%h", bus.iss_valid, iss_w, e[0]); end
    for (int i = 2; i < 5; i++) begin
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_accept%0d got %b exp 1", i, bus.in_ready); end
      drive(1'b1, e[i]);
      step();
    end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_low got %b exp 0", bus.in_ready); end
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL full_stalled got %b exp 0", bus.iss_valid); end
    drive(1'b1, e[5]);
    step();
    tests++; if (iss_w !== e[1] || bus.iss_valid !== 1'b1) begin fails++; $display("FAIL full_head got %b/%h exp 1/%h", bus.iss_valid, iss_w, e[1]); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_back got %b exp 1", bus.in_ready); end
    step();
    drive(1'b0, '0);
    for (int i = 2; i < 6; i++) begin
      if (i > 2) step();
      tests++; if (iss_w !== e[i] || bus.iss_valid !== 1'b1) begin fails++; $display("FAIL full_order%0d got %b/%h exp 1/%h", i, bus.iss_valid, iss_w, e[i]); end
    end
    step();
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL full_no_dup got %b exp 0", bus.iss_valid); end
    tests++; if (issue_cnt !== 4'd6) begin fails++; $display("FAIL full_issue_cnt got %0d exp 6", issue_cnt); end
    tests++; if (stall_cnt !== 4'd3) begin fails++; $display("FAIL full_stall_cnt got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_flush();
    logic [23:0] p, d;
    p = ins(0, 0, 5, 0, 1);
    d = ins(5, 0, 6, 0, 2);
    do_reset();
    drive(1'b1, p);
    step();
    drive(1'b1, d);
    step();
    drive(1'b1, ins(6, 1, 7, 1, 3));
    step();
    drive(1'b1, ins(1, 1, 8, 1, 4));
    step();
    drive(1'b1, ins(2, 2, 9, 2, 5));
    step();
    drive(1'b0, '0);
    step();
    tests++; if (iss_w !== d || bus.iss_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_issue got %b/%h exp 1/%h", bus.iss_valid, iss_w, d); end
    flush = 1'b1;
    drive(1'b1, ins(3, 3, 12, 3, 6));
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL flush_no_issue got %b exp 0", bus.iss_valid); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy0 got %b exp 1", busy); end
    step();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy1 got %b exp 1", busy); end
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_drained got %b exp 0", busy); end
    step();
    step();
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL flush_nothing_left got %b exp 0", bus.iss_valid); end
    tests++; if (iss_w !== d) begin fails++; $display("FAIL flush_hold got %h exp %h", iss_w, d); end
    tests++; if (issue_cnt !== 4'd2) begin fails++; $display("FAIL flush_issue_cnt got %0d exp 2", issue_cnt); end
    tests++; if (stall_cnt !== 4'd3) begin fails++; $display("FAIL flush_stall_cnt got %0d exp 3", stall_cnt); end
  endtask

  task automatic test_saturation();
    int n = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, ins(0, 0, 1, i, i));
      step();
      n += int'(bus.iss_valid);
    end
    drive(1'b0, '0);
    step();
    n += int'(bus.iss_valid);
    step();
    n += int'(bus.iss_valid);
    tests++; if (n !== 20) begin fails++; $display("FAIL sat_issued got %0d exp 20", n); end
    tests++; if (issue_cnt !== 4'hf) begin fails++; $display("FAIL sat_issue_cnt got %0d exp 15", issue_cnt); end
    tests++; if (stall_cnt !== 4'd0) begin fails++; $display("FAIL sat_stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, ins(0, 0, 5, 0, 1));
    step();
    drive(1'b1, ins(5, 0, 6, 0, 2));
    step();
    drive(1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mrst_busy got %b exp 0", busy); end
    tests++; if (issue_cnt !== 4'd0 || stall_cnt !== 4'd0) begin fails++; $display("FAIL mrst_cnts got %0d/%0d exp 0/0", issue_cnt, stall_cnt); end
    tests++; if (iss_w !== 24'd0) begin fails++; $display("FAIL mrst_fields got %h exp 0", iss_w); end
    step();
    tests++; if (bus.iss_valid !== 1'b0) begin fails++; $display("FAIL mrst_discard got %b exp 0", bus.iss_valid); end
  endtask

  initial begin
    drive(1'b0, '0);
    test_reset();
    test_independent();
    test_raw(1'b0);
    test_raw(1'b1);
    test_full();
    test_flush();
    test_saturation();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
